// File: rtl/fwd_hazard_ctrl_if.sv
// Bundle between ID-stage decode and the forwarding/hazard controller.
// trk_wb exposes the WB shadow entry as {valid, wr, ld, dst} for observation.
interface fwd_hazard_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              enable;
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic [ADDR_W-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic [1:0]        ex_sel_a;
  logic [1:0]        ex_sel_b;
  logic              stall_if_id;
  logic              bubble_id_ex;
  logic [CNT_W-1:0]  stall_count;
  logic [ADDR_W+2:0] trk_wb;

  modport master (
    output enable, id_valid, id_rs, id_rt, id_rd, id_reg_write, id_mem_read,
    input  ex_sel_a, ex_sel_b, stall_if_id, bubble_id_ex, stall_count, trk_wb
  );

  modport slave (
    input  enable, id_valid, id_rs, id_rt, id_rd, id_reg_write, id_mem_read,
    output ex_sel_a, ex_sel_b, stall_if_id, bubble_id_ex, stall_count, trk_wb
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Operand-forward select generation and load-use stall detection for the
// EX stage. Keeps a shadow of destination info for the EX, MEM and WB stages.
// Select codes: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
module fwd_hazard_ctrl #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          arst,
  fwd_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic              ld;
    logic [ADDR_W-1:0] dst;
  } trk_t;

  trk_t             t_ex_q, t_ex_d;
  trk_t             t_mem_q, t_mem_d;
  trk_t             t_wb_q, t_wb_d;
  logic [1:0]       sel_a_q, sel_a_d;
  logic [1:0]       sel_b_q, sel_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fwd_a, fwd_b;
  logic             hz;

  // An entry only counts as a producer for a real, non-zero destination.
  function automatic logic produces(input trk_t t, input logic [ADDR_W-1:0] r);
    return t.valid & t.wr & (t.dst == r) & (r != '0);
  endfunction

  // Youngest producer wins: the EX entry shadows an older MEM write.
  function automatic logic [1:0] fwd_sel(input trk_t ex, input trk_t mem,
                                         input logic [ADDR_W-1:0] r);
    if (produces(ex, r))  return 2'b01;
    if (produces(mem, r)) return 2'b10;
    return 2'b00;
  endfunction

  // Load in EX feeding the ID instruction: its data is not ready for EX/MEM forwarding.
  assign hz = bus.id_valid & t_ex_q.ld &
              (produces(t_ex_q, bus.id_rs) | produces(t_ex_q, bus.id_rt));

  assign bus.stall_if_id  = hz & bus.enable;
  assign bus.bubble_id_ex = hz & bus.enable;
  assign bus.ex_sel_a     = sel_a_q;
  assign bus.ex_sel_b     = sel_b_q;
  assign bus.stall_count  = cnt_q;
  assign bus.trk_wb       = t_wb_q;

  // Next-state: shift trackers, insert the ID instruction or a bubble, count stalls.
  always_comb begin
    t_ex_d  = t_ex_q;
    t_mem_d = t_mem_q;
    t_wb_d  = t_wb_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    cnt_d   = cnt_q;
    fwd_a   = fwd_sel(t_ex_q, t_mem_q, bus.id_rs);
    fwd_b   = fwd_sel(t_ex_q, t_mem_q, bus.id_rt);
    if (bus.enable) begin
      t_wb_d  = t_mem_q;
      t_mem_d = t_ex_q;
      if (hz) begin
        t_ex_d  = '0;
        sel_a_d = 2'b00;
        sel_b_d = 2'b00;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else begin
        t_ex_d  = '{valid: bus.id_valid, wr: bus.id_reg_write,
                    ld: bus.id_mem_read, dst: bus.id_rd};
        sel_a_d = fwd_a;
        sel_b_d = fwd_b;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      t_ex_q  <= '0;
      t_mem_q <= '0;
      t_wb_q  <= '0;
      sel_a_q <= 2'b00;
      sel_b_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      t_ex_q  <= t_ex_d;
      t_mem_q <= t_mem_d;
      t_wb_q  <= t_wb_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
